// File: rtl/energy_accumulator.sv
// Saturating per-frame energy accumulator: sums signed terms on a valid/ready
// input port and presents the closed frame's energy on a valid/ready output port.
module energy_accumulator #(
   parameter int TERM_BITWIDTH    = 16,
   parameter int ENERGY_BITWIDTH  = 32,
   parameter int COUNTER_BITWIDTH = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               en_i,
   input  logic                               clear_i,
   input  logic                               term_valid_i,
   input  logic signed [TERM_BITWIDTH-1:0]    term_i,
   output logic                               term_ready_o,
   input  logic                               counter_finish_i,
   input  logic                               counter_overflow_i,
   output logic                               energy_valid_o,
   output logic signed [ENERGY_BITWIDTH-1:0]  energy_o,
   input  logic                               energy_ready_i,
   output logic                               saturated_o,
   output logic                               error_o,
   output logic [COUNTER_BITWIDTH-1:0]        term_count_o
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [ENERGY_BITWIDTH-1:0] MAX_ENERGY = {1'b0, {(ENERGY_BITWIDTH-1){1'b1}}};
   localparam logic [ENERGY_BITWIDTH-1:0] MIN_ENERGY = {1'b1, {(ENERGY_BITWIDTH-1){1'b0}}};

   state_t                       r_state;
   state_t                       w_stateNext;
   logic [ENERGY_BITWIDTH-1:0]   r_acc;
   logic [COUNTER_BITWIDTH-1:0]  r_count;
   logic                         r_sticky;
   logic [ENERGY_BITWIDTH-1:0]   r_energy;
   logic                         r_valid;
   logic                         r_sat;
   logic                         r_err;

   logic [ENERGY_BITWIDTH:0]     w_termExt;
   logic [ENERGY_BITWIDTH:0]     w_sumWide;
   logic                         w_clamp;
   logic [ENERGY_BITWIDTH-1:0]   w_accNext;
   logic                         w_termHs;
   logic                         w_close;
   logic                         w_outHs;

   // One guard bit above the accumulator exposes signed overflow of the add.
   assign w_termExt = {{(ENERGY_BITWIDTH-TERM_BITWIDTH+1){term_i[TERM_BITWIDTH-1]}}, term_i};
   assign w_sumWide = {r_acc[ENERGY_BITWIDTH-1], r_acc} + w_termExt;
   assign w_clamp   = w_sumWide[ENERGY_BITWIDTH] != w_sumWide[ENERGY_BITWIDTH-1];
   assign w_accNext = !w_clamp ? w_sumWide[ENERGY_BITWIDTH-1:0]
                    : (w_sumWide[ENERGY_BITWIDTH] ? MIN_ENERGY : MAX_ENERGY);

   assign term_ready_o = !rst_i && !clear_i && en_i && (r_state == ACCUM);
   assign w_termHs     = term_ready_o && term_valid_i;
   assign w_close      = w_termHs && (counter_finish_i || counter_overflow_i);
   assign w_outHs      = !clear_i && en_i && (r_state == HOLD) && r_valid && energy_ready_i;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ACCUM:   if (w_close) w_stateNext = HOLD;
         HOLD:    if (w_outHs) w_stateNext = ACCUM;
         default: w_stateNext = ACCUM;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // The closing term's clamp must reach saturated_o, so it is folded in directly.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_acc    <= '0;
         r_count  <= '0;
         r_sticky <= 1'b0;
         r_energy <= '0;
         r_valid  <= 1'b0;
         r_sat    <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_termHs) begin
         r_acc    <= w_accNext;
         r_count  <= r_count + 1'b1;
         r_sticky <= r_sticky | w_clamp;
         if (w_close) begin
            r_energy <= w_accNext;
            r_valid  <= 1'b1;
            r_sat    <= r_sticky | w_clamp;
            r_err    <= counter_overflow_i;
         end
      end else if (w_outHs) begin
         r_acc    <= '0;
         r_count  <= '0;
         r_sticky <= 1'b0;
         r_valid  <= 1'b0;
         r_sat    <= 1'b0;
         r_err    <= 1'b0;
      end
   end

   assign energy_valid_o = r_valid;
   assign energy_o       = r_energy;
   assign saturated_o    = r_sat;
   assign error_o        = r_err;
   assign term_count_o   = r_count;

endmodule

// File: tb/tb_energy_accumulator.sv
// Bench for energy_accumulator: two widths driven in lockstep, directed table
// plus randomized traffic compared against an arithmetic frame model.
module tb_energy_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, clr, tv, fin, ovf, rdy;
   logic signed [15:0] term;

   logic ready32, valid32, sat32, err32;
   logic [7:0] count32;
   logic signed [31:0] energy32;
   logic ready16, valid16, sat16, err16;
   logic [7:0] count16;
   logic signed [15:0] energy16;

   energy_accumulator #(.TERM_BITWIDTH(16), .ENERGY_BITWIDTH(32), .COUNTER_BITWIDTH(8)) dut32 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .term_valid_i(tv), .term_i(term),
      .term_ready_o(ready32), .counter_finish_i(fin), .counter_overflow_i(ovf),
      .energy_valid_o(valid32), .energy_o(energy32), .energy_ready_i(rdy),
      .saturated_o(sat32), .error_o(err32), .term_count_o(count32));

   energy_accumulator #(.TERM_BITWIDTH(16), .ENERGY_BITWIDTH(16), .COUNTER_BITWIDTH(8)) dut16 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .term_valid_i(tv), .term_i(term),
      .term_ready_o(ready16), .counter_finish_i(fin), .counter_overflow_i(ovf),
      .energy_valid_o(valid16), .energy_o(energy16), .energy_ready_i(rdy),
      .saturated_o(sat16), .error_o(err16), .term_count_o(count16));

   int checks = 0;
   int errors = 0;
   bit regsKnown = 1'b0;

   // Frame model: index 0 is the 32-bit accumulator, index 1 the 16-bit one.
   bit     mHold, mValid, mErr;
   int     mCount;
   longint mAcc[2], mEnergy[2];
   bit     mSticky[2], mSat[2];

   typedef struct {
      bit rst, clr, en, tv; int term; bit fin, ovf, rdy;
      bit exReady, exValid; int exE32, exE16, exCount; bit exSat, exSat16, exErr;
   } vec_t;
   vec_t vecs[$];

   function automatic longint widthMax(int i);
      return (i == 0) ? 64'sd2147483647 : 64'sd32767;
   endfunction

   task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      bit expReady;
      expReady = !rst && !clr && en && !mHold;
      check("ready32", {63'd0, ready32}, {63'd0, expReady});
      check("ready16", {63'd0, ready16}, {63'd0, expReady});
      if (regsKnown) begin
         check("valid32", {63'd0, valid32}, {63'd0, mValid});
         check("valid16", {63'd0, valid16}, {63'd0, mValid});
         check("energy32", 64'(energy32), mEnergy[0]);
         check("energy16", 64'(energy16), mEnergy[1]);
         check("count32", {56'd0, count32}, 64'(mCount));
         check("count16", {56'd0, count16}, 64'(mCount));
         check("sat32", {63'd0, sat32}, {63'd0, mSat[0]});
         check("sat16", {63'd0, sat16}, {63'd0, mSat[1]});
         check("err32", {63'd0, err32}, {63'd0, mErr});
         check("err16", {63'd0, err16}, {63'd0, mErr});
      end
   endtask

   task automatic modelStep();
      longint s;
      if (rst || clr) begin
         mHold = 0; mValid = 0; mErr = 0; mCount = 0;
         for (int i = 0; i < 2; i++) begin
            mAcc[i] = 0; mEnergy[i] = 0; mSticky[i] = 0; mSat[i] = 0;
         end
      end else if (en && !mHold && tv) begin
         mCount = (mCount + 1) % 256;
         for (int i = 0; i < 2; i++) begin
            s = mAcc[i] + longint'(term);
            if (s > widthMax(i))       begin s = widthMax(i);      mSticky[i] = 1; end
            else if (s < -widthMax(i) - 1) begin s = -widthMax(i) - 1; mSticky[i] = 1; end
            mAcc[i] = s;
         end
         if (fin || ovf) begin
            mHold = 1; mValid = 1; mErr = ovf;
            for (int i = 0; i < 2; i++) begin
               mEnergy[i] = mAcc[i]; mSat[i] = mSticky[i];
            end
         end
      end else if (en && mHold && rdy) begin
         mHold = 0; mValid = 0; mErr = 0; mCount = 0;
         for (int i = 0; i < 2; i++) begin
            mAcc[i] = 0; mSticky[i] = 0; mSat[i] = 0;
         end
      end
   endtask

   task automatic applyStimulus(bit r, bit c, bit e, bit v, int t, bit f, bit o, bit d);
      @(negedge clk);
      rst = r; clr = c; en = e; tv = v; term = 16'(t); fin = f; ovf = o; rdy = d;
      #1;
      checkOutput();
      modelStep();
      if (r) regsKnown = 1'b1;
   endtask

   initial begin
      rst = 1; clr = 0; en = 1; tv = 0; term = '0; fin = 0; ovf = 0; rdy = 0;

      //              rst clr en tv term   fin ovf rdy  rdyO val e32 e16 cnt sat s16 err
      vecs.push_back('{0,0,1,1,5,0,0,0,        1,0,0,0,0,0,0,0});
      vecs.push_back('{0,0,1,1,-3,0,0,0,       1,0,0,0,1,0,0,0});
      vecs.push_back('{0,0,1,1,10,1,0,0,       1,0,0,0,2,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,0,        0,1,12,12,3,0,0,0});
      vecs.push_back('{0,0,1,1,99,0,0,0,       0,1,12,12,3,0,0,0});
      vecs.push_back('{0,0,1,1,99,0,0,0,       0,1,12,12,3,0,0,0});
      vecs.push_back('{0,0,1,1,99,0,0,0,       0,1,12,12,3,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,1,        0,1,12,12,3,0,0,0});
      vecs.push_back('{0,0,1,1,7,0,0,0,        1,0,12,12,0,0,0,0});
      vecs.push_back('{0,0,1,1,7,0,1,0,        1,0,12,12,1,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,1,        0,1,14,14,2,0,0,1});
      vecs.push_back('{0,0,1,1,1,0,0,0,        1,0,14,14,0,0,0,0});
      vecs.push_back('{0,0,1,1,2,0,0,0,        1,0,14,14,1,0,0,0});
      vecs.push_back('{0,1,1,1,50,0,0,0,       0,0,14,14,2,0,0,0});
      vecs.push_back('{0,0,1,1,4,1,0,0,        1,0,0,0,0,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,0,        0,1,4,4,1,0,0,0});
      vecs.push_back('{0,0,0,0,0,0,0,1,        0,1,4,4,1,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,1,        0,1,4,4,1,0,0,0});
      vecs.push_back('{0,0,1,1,6,0,0,0,        1,0,4,4,0,0,0,0});
      vecs.push_back('{0,0,0,1,6,0,0,0,        0,0,4,4,1,0,0,0});
      vecs.push_back('{0,0,0,1,6,0,0,0,        0,0,4,4,1,0,0,0});
      vecs.push_back('{0,0,0,1,6,0,0,0,        0,0,4,4,1,0,0,0});
      vecs.push_back('{0,0,1,1,6,1,0,0,        1,0,4,4,1,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,0,        0,1,12,12,2,0,0,0});
      vecs.push_back('{0,1,1,0,0,0,0,0,        0,1,12,12,2,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,0,        1,0,0,0,0,0,0,0});
      vecs.push_back('{0,0,1,1,1,1,0,0,        1,0,0,0,0,0,0,0});
      vecs.push_back('{1,0,1,0,0,0,0,0,        0,1,1,1,1,0,0,0});
      vecs.push_back('{0,0,1,1,32000,0,0,0,    1,0,0,0,0,0,0,0});
      vecs.push_back('{0,0,1,1,32000,1,0,0,    1,0,0,0,1,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,1,        0,1,64000,32767,2,0,1,0});
      vecs.push_back('{0,0,1,1,-32000,0,0,0,   1,0,64000,32767,0,0,0,0});
      vecs.push_back('{0,0,1,1,-32000,1,0,0,   1,0,64000,32767,1,0,0,0});
      vecs.push_back('{0,0,1,0,0,0,0,1,        0,1,-64000,-32768,2,0,1,0});
      vecs.push_back('{0,0,1,0,0,0,0,0,        1,0,-64000,-32768,0,0,0,0});

      $display("[TB] reset and directed vectors");
      applyStimulus(1, 0, 1, 1, 5, 0, 0, 0);
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst, vecs[k].clr, vecs[k].en, vecs[k].tv,
                       vecs[k].term, vecs[k].fin, vecs[k].ovf, vecs[k].rdy);
         check($sformatf("vec%0d ready", k), {63'd0, ready32}, {63'd0, vecs[k].exReady});
         check($sformatf("vec%0d valid", k), {63'd0, valid32}, {63'd0, vecs[k].exValid});
         check($sformatf("vec%0d energy32", k), 64'(energy32), 64'(vecs[k].exE32));
         check($sformatf("vec%0d energy16", k), 64'(energy16), 64'(vecs[k].exE16));
         check($sformatf("vec%0d count", k), {56'd0, count32}, 64'(vecs[k].exCount));
         check($sformatf("vec%0d sat32", k), {63'd0, sat32}, {63'd0, vecs[k].exSat});
         check($sformatf("vec%0d sat16", k), {63'd0, sat16}, {63'd0, vecs[k].exSat16});
         check($sformatf("vec%0d err", k), {63'd0, err32}, {63'd0, vecs[k].exErr});
      end

      // Long frames without finish exercise count wrap and wide saturation.
      $display("[TB] randomized traffic");
      for (int n = 0; n < 4000; n++) begin
         int t;
         t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) - 20
                                         : int'($signed(16'($urandom)));
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
                       $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, t,
                       $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
                       $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/energy_accumulator.md
Name: energy_accumulator

Overview:
- Downstream consumer of the energy-monitor step counter.
- Sums one signed partial-energy term per step handshake into a saturating accumulator.
- Uses the counter's finish/overflow flags to close a frame, then presents the frame energy on a valid/ready output port.
- Sits between the step counter / term datapath and the energy monitor's comparator/readout.

Parameters:
- TERM_BITWIDTH, 16, width of each signed partial-energy term.
- ENERGY_BITWIDTH, 32, width of the signed accumulator and output; must be ≥ TERM_BITWIDTH.
- COUNTER_BITWIDTH, 8, width of the internal accepted-term count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset (synchronous, active-high).
- en_i  in  1  global enable; low = freeze all state.
- clear_i  in  1  abort the current frame and zero the accumulator.
- term_valid_i  in  1  term available.
- term_i  in  TERM_BITWIDTH  signed partial-energy term.
- term_ready_o  out  1  block accepts a term.
- counter_finish_i  in  1  counter finish flag; qualifies the current term as the last one.
- counter_overflow_i  in  1  counter overflow flag.
- energy_valid_o  out  1  frame energy valid.
- energy_o  out  ENERGY_BITWIDTH  signed frame energy.
- energy_ready_i  in  1  consumer accepts the energy.
- saturated_o  out  1  frame result was clamped.
- error_o  out  1  frame was closed by counter overflow.
- term_count_o  out  COUNTER_BITWIDTH  terms accepted in the current frame.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset: state ACCUM; accumulator = 0; term_count_o = 0; energy_o = 0; energy_valid_o = 0; saturated_o = 0; error_o = 0. term_ready_o = 0 during the reset cycle.
- Priority: rst_i > clear_i > en_i == 0 > normal operation.
- clear_i (when en_i is ignored): next state ACCUM; accumulator and count = 0; energy_valid_o = 0; saturated_o and error_o = 0. A term presented in the same cycle is not accepted (term_ready_o = 0 while clear_i is high).
- en_i = 0: all registers hold; term_ready_o = 0. energy_valid_o holds its value, but no output handshake completes.
- State ACCUM:
  - term_ready_o = en_i.
  - Term handshake: acc <= sat(acc + sext(term_i)); count <= count + 1, wrapping modulo 2^COUNTER_BITWIDTH.
  - sat() clamps to the signed ENERGY_BITWIDTH max/min; any clamp sets an internal sticky flag for the frame.
  - Finish: if counter_finish_i or counter_overflow_i is high in the handshake cycle, the result includes that term. Next cycle:
    - energy_o = new acc; energy_valid_o = 1;
    - saturated_o = sticky flag, including a clamp on the final term;
    - error_o = counter_overflow_i;
    - state HOLD.
  - counter_finish_i without term_valid_i: ignored, no frame close.
- State HOLD:
  - term_ready_o = 0.
  - energy_o, saturated_o, error_o and term_count_o stay stable while energy_valid_o is high.
  - On energy_valid_o && energy_ready_i: next cycle energy_valid_o = 0; acc, count, sticky flag, saturated_o and error_o = 0; state ACCUM.
  - First new term is accepted no earlier than the cycle after the output handshake.
- Latency: final term handshake → energy_valid_o = 1 on the next edge, exactly 1 cycle.
- Throughput: 1 term/cycle in ACCUM; at least 1 bubble cycle per frame.
- Output handshake: energy_valid_o never drops without a handshake, except on clear_i or rst_i.
- Sign extension: term_i is treated as two's complement and sign-extended to ENERGY_BITWIDTH before the add.
- Single-term frame: finish on the first handshake → energy_o = sext(term).

Test Plan:
- Reset, then terms 5, -3, 10 with finish on the 3rd → energy_o = 12 one cycle later; term_count_o = 3; saturated_o = 0; error_o = 0; term_ready_o = 0 until the output handshake.
- Hold energy_ready_i low 4 cycles after the result → energy_o stable at 12; no terms accepted. Assert ready → valid drops next cycle; next frame starts from 0.
- ENERGY_BITWIDTH = 16, TERM_BITWIDTH = 16: terms 32000, 32000, finish → energy_o = 32767, saturated_o = 1. Repeat with -32000, -32000 → energy_o = -32768.
- Terms 7, 7 with counter_overflow_i on the 2nd → energy_o = 14, error_o = 1.
- clear_i mid-frame after 2 terms, simultaneous with term_valid_i → term not accepted; acc = 0, count = 0. Then term 4 with finish → energy_o = 4.
- en_i low for 3 cycles mid-frame with term_valid_i high → no accepts, state frozen. Also assert clear_i and rst_i in HOLD → energy_valid_o = 0 next cycle, all outputs reset.
